// File: rtl/bcp_trail_controller.sv
// bcp_trail_controller: LIFO assignment trail with level tagging and backtrack-driven unassign broadcasts.
module bcp_trail_controller #(
  parameter int FORMULA_MAX_VARIABLE  = 20,
  parameter int VARIABLE_ENCODING_LEN = $clog2(FORMULA_MAX_VARIABLE+1),
  parameter int TRAIL_DEPTH           = FORMULA_MAX_VARIABLE,
  parameter int LEVEL_LEN             = $clog2(FORMULA_MAX_VARIABLE+1),
  parameter int COUNT_LEN             = $clog2(TRAIL_DEPTH+1)
)(
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             push_valid_i,
  output logic                             push_ready_o,
  input  logic [VARIABLE_ENCODING_LEN-1:0] push_var_id_i,
  input  logic                             push_assignment_i,
  input  logic                             push_is_decision_i,
  input  logic                             bt_req_i,
  input  logic [LEVEL_LEN-1:0]             bt_level_i,
  output logic                             bt_busy_o,
  output logic                             bt_done_o,
  output logic                             unassign_valid_o,
  input  logic                             unassign_ready_i,
  output logic [VARIABLE_ENCODING_LEN-1:0] unassign_var_id_o,
  output logic                             unassign_assignment_o,
  output logic [LEVEL_LEN-1:0]             level_o,
  output logic [COUNT_LEN-1:0]             count_o,
  output logic                             overflow_o,
  output logic                             illegal_id_o
);
  localparam logic [1:0] IDLE = 2'd0, POP = 2'd1, DONE = 2'd2;
  localparam logic [COUNT_LEN-1:0] DEPTH_C = COUNT_LEN'(TRAIL_DEPTH);
  localparam logic [VARIABLE_ENCODING_LEN-1:0] MAX_ID = VARIABLE_ENCODING_LEN'(FORMULA_MAX_VARIABLE);
  logic [VARIABLE_ENCODING_LEN-1:0] mem_var [TRAIL_DEPTH];
  logic                             mem_asg [TRAIL_DEPTH];
  logic                             mem_dec [TRAIL_DEPTH];
  logic [LEVEL_LEN-1:0]             mem_lvl [TRAIL_DEPTH];
  logic [1:0]                       state_q, state_d;
  logic [COUNT_LEN-1:0]             count_q, count_d, top, nxt;
  logic [LEVEL_LEN-1:0]             level_q, level_d, target_q, target_d, push_lvl;
  logic [VARIABLE_ENCODING_LEN-1:0] uvar_q, uvar_d;
  logic                             valid_q, valid_d, uasg_q, uasg_d;
  logic                             ovf_q, ovf_d, ill_q, ill_d;
  logic                             attempt, bad_id, sat, accept, pop_ack, more;
  assign top          = count_q - COUNT_LEN'(1);
  assign nxt          = count_q - COUNT_LEN'(2);
  assign attempt      = push_valid_i && state_q == IDLE && !bt_req_i;
  assign push_ready_o = rst_ni && state_q == IDLE && !bt_req_i && count_q != DEPTH_C;
  assign bad_id       = push_var_id_i == '0 || push_var_id_i > MAX_ID;
  assign sat          = push_is_decision_i && level_q == '1;
  assign accept       = push_valid_i && push_ready_o && !bad_id && !sat;
  assign push_lvl     = level_q + LEVEL_LEN'(push_is_decision_i);
  assign pop_ack      = state_q == POP && unassign_ready_i;
  // Keep popping only while the entry that becomes the new top is still above the target.
  assign more         = count_q != COUNT_LEN'(1) && mem_lvl[nxt] > target_q;
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    level_d  = level_q;
    target_d = target_q;
    valid_d  = valid_q;
    uvar_d   = uvar_q;
    uasg_d   = uasg_q;
    ovf_d    = ovf_q | (attempt && (count_q == DEPTH_C || sat));
    ill_d    = ill_q | (attempt && bad_id);
    if (accept) begin
      count_d = count_q + COUNT_LEN'(1);
      level_d = push_lvl;
    end
    if (state_q == IDLE && bt_req_i) begin
      target_d = bt_level_i;
      state_d  = (count_q != '0 && mem_lvl[top] > bt_level_i) ? POP : DONE;
      valid_d  = count_q != '0 && mem_lvl[top] > bt_level_i;
      uvar_d   = valid_d ? mem_var[top] : '0;
      uasg_d   = valid_d && mem_asg[top];
    end
    if (pop_ack) begin
      count_d = top;
      level_d = level_q - LEVEL_LEN'(mem_dec[top]);
      state_d = more ? POP : DONE;
      valid_d = more;
      uvar_d  = more ? mem_var[nxt] : '0;
      uasg_d  = more && mem_asg[nxt];
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      count_q  <= '0;
      level_q  <= '0;
      target_q <= '0;
      valid_q  <= 1'b0;
      uvar_q   <= '0;
      uasg_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      level_q  <= level_d;
      target_q <= target_d;
      valid_q  <= valid_d;
      uvar_q   <= uvar_d;
      uasg_q   <= uasg_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem_var[count_q] <= push_var_id_i;
      mem_asg[count_q] <= push_assignment_i;
      mem_dec[count_q] <= push_is_decision_i;
      mem_lvl[count_q] <= push_lvl;
    end
  end
  assign bt_busy_o             = state_q == POP || state_q == DONE;
  assign bt_done_o             = state_q == DONE;
  assign unassign_valid_o      = valid_q;
  assign unassign_var_id_o     = uvar_q;
  assign unassign_assignment_o = uasg_q;
  assign level_o               = level_q;
  assign count_o               = count_q;
  assign overflow_o            = ovf_q;
  assign illegal_id_o          = ill_q;
endmodule

// File: tb/tb_bcp_trail_controller.sv
// tb_bcp_trail_controller: randomized and directed checks of the trail controller against a queue-based model.
module tb_bcp_trail_controller;
  logic       clk_i = 1'b0, rst_ni = 1'b0;
  logic       push_valid_i = 1'b0, push_ready_o;
  logic [4:0] push_var_id_i = '0;
  logic       push_assignment_i = 1'b0, push_is_decision_i = 1'b0;
  logic       bt_req_i = 1'b0;
  logic [4:0] bt_level_i = '0;
  logic       bt_busy_o, bt_done_o, unassign_valid_o, unassign_ready_i = 1'b0;
  logic [4:0] unassign_var_id_o;
  logic       unassign_assignment_o;
  logic [4:0] level_o, count_o;
  logic       overflow_o, illegal_id_o;
  typedef struct packed {logic [4:0] v; logic a; logic d; logic [4:0] l;} ent_t;
  ent_t q[$];
  int   m_lvl = 0;
  bit   m_ovf = 0, m_ill = 0;
  int   n_cmp = 0, n_err = 0;
  bcp_trail_controller dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_var_id_i(push_var_id_i), .push_assignment_i(push_assignment_i),
    .push_is_decision_i(push_is_decision_i),
    .bt_req_i(bt_req_i), .bt_level_i(bt_level_i),
    .bt_busy_o(bt_busy_o), .bt_done_o(bt_done_o),
    .unassign_valid_o(unassign_valid_o), .unassign_ready_i(unassign_ready_i),
    .unassign_var_id_o(unassign_var_id_o), .unassign_assignment_o(unassign_assignment_o),
    .level_o(level_o), .count_o(count_o),
    .overflow_o(overflow_o), .illegal_id_o(illegal_id_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic check_state();
    check("count", count_o, q.size());
    check("level", level_o, m_lvl);
    check("overflow", overflow_o, m_ovf);
    check("illegal", illegal_id_o, m_ill);
  endtask
  task automatic push(input int v, input bit a, input bit d);
    bit full = q.size() == 20;
    bit bad = v == 0 || v > 20;
    push_valid_i = 1'b1;
    push_var_id_i = 5'(v);
    push_assignment_i = a;
    push_is_decision_i = d;
    #1;
    check("push_ready", push_ready_o, !full);
    tick();
    push_valid_i = 1'b0;
    if (full) m_ovf = 1;
    if (bad) m_ill = 1;
    if (!full && !bad) begin
      if (d && m_lvl == 31) m_ovf = 1;
      else begin
        m_lvl += int'(d);
        q.push_back('{v: 5'(v), a: a, d: d, l: 5'(m_lvl)});
      end
    end
    check_state();
  endtask
  task automatic backtrack(input int tgt, input bit rnd, input bit with_push);
    ent_t exp_q[$];
    ent_t e;
    int   idx = 0, first = -1, done_c = -1;
    while (q.size() > 0 && int'(q[$].l) > tgt) begin
      e = q.pop_back();
      exp_q.push_back(e);
      if (e.d) m_lvl--;
    end
    bt_req_i = 1'b1;
    bt_level_i = 5'(tgt);
    if (with_push) begin
      push_valid_i = 1'b1;
      push_var_id_i = 5'd9;
      push_is_decision_i = 1'b0;
    end
    #1;
    check("ready_during_req", push_ready_o, 0);
    tick();
    bt_req_i = 1'b0;
    push_valid_i = 1'b0;
    for (int c = 1; c <= 200 && done_c < 0; c++) begin
      unassign_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      check("ready_busy", push_ready_o, 0);
      check("busy", bt_busy_o, 1);
      if (bt_done_o) done_c = c;
      else if (unassign_valid_o) begin
        if (idx < exp_q.size()) begin
          check("unassign_var", unassign_var_id_o, exp_q[idx].v);
          check("unassign_asg", unassign_assignment_o, exp_q[idx].a);
        end else check("extra_unassign", 1, 0);
        if (first < 0) first = c;
        if (unassign_ready_i) idx++;
      end
      bt_req_i = (done_c < 0 && rnd) ? ($urandom_range(0, 3) == 0) : 1'b0;
      tick();
    end
    bt_req_i = 1'b0;
    unassign_ready_i = 1'b0;
    check("bt_done_seen", done_c > 0, 1);
    check("pop_count", idx, exp_q.size());
    if (!rnd) check("done_latency", done_c, exp_q.size() + 1);
    if (!rnd && exp_q.size() > 0) check("first_latency", first, 1);
    check("done_pulse", bt_done_o, 0);
    check("idle_busy", bt_busy_o, 0);
    check_state();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #1;
    check("rst_ready", push_ready_o, 0);
    check("rst_busy", bt_busy_o, 0);
    check("rst_done", bt_done_o, 0);
    check("rst_valid", unassign_valid_o, 0);
    check("rst_var", unassign_var_id_o, 0);
    check("rst_asg", unassign_assignment_o, 0);
    check_state();
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    check("idle_ready", push_ready_o, 1);
    push(3, 1, 1);
    push(5, 0, 0);
    push(7, 1, 1);
    push(2, 1, 0);
    backtrack(1, 0, 0);
    push(7, 1, 1);
    push(2, 1, 0);
    backtrack(1, 1, 0);
    push(7, 1, 1);
    backtrack(3, 0, 0);
    backtrack(3, 0, 1);
    push(0, 1, 0);
    push(27, 0, 1);
    while (q.size() < 20) push($urandom_range(1, 20), 1'($urandom_range(0, 1)), 1'b0);
    push(11, 1, 0);
    push(12, 0, 1);
    check("full_ready", push_ready_o, 0);
    backtrack(0, 0, 0);
    push(4, 0, 1);
    push(6, 1, 0);
    push(8, 1, 1);
    bt_req_i = 1'b1;
    bt_level_i = 5'd0;
    unassign_ready_i = 1'b0;
    tick();
    bt_req_i = 1'b0;
    tick();
    check("pop_valid_before_rst", unassign_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    check("arst_valid", unassign_valid_o, 0);
    check("arst_busy", bt_busy_o, 0);
    check("arst_done", bt_done_o, 0);
    check("arst_count", count_o, 0);
    check("arst_level", level_o, 0);
    check("arst_ready", push_ready_o, 0);
    q.delete();
    m_lvl = 0;
    m_ovf = 0;
    m_ill = 0;
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_done", bt_done_o, 0);
    end
    check_state();
    for (int i = 0; i < 250; i++) begin
      int r = $urandom_range(0, 9);
      if (r < 6) begin
        int v = $urandom_range(1, 20);
        if ($urandom_range(0, 9) == 0) v = $urandom_range(0, 1) ? 0 : $urandom_range(21, 31);
        push(v, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
      end else if (r < 8) backtrack($urandom_range(0, m_lvl + 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else begin
        tick();
        check_state();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bcp_trail_controller.md
Name: bcp_trail_controller

Overview:
- Sequences the clause-module array for backtracking.
- Records every decision and implication broadcast as a trail entry tagged with its decision level.
- On a backtrack request, pops entries above the target level, newest first, one per handshake. Each pop drives an unassign broadcast to the clause array.
- Sits between the top-level BCP control FSM (push/backtrack requests) and the clause-module broadcast bus.

Parameters:
FORMULA_MAX_VARIABLE, 20, highest legal variable id; id 0 is reserved/illegal
VARIABLE_ENCODING_LEN, $clog2(FORMULA_MAX_VARIABLE+1), variable id width
TRAIL_DEPTH, FORMULA_MAX_VARIABLE, trail entries (one per variable)
LEVEL_LEN, $clog2(FORMULA_MAX_VARIABLE+1), decision level width
COUNT_LEN, $clog2(TRAIL_DEPTH+1), trail occupancy width

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
push_valid_i  input  1  new assignment to record
push_ready_o  output  1  trail accepts push this cycle
push_var_id_i  input  VARIABLE_ENCODING_LEN  assigned variable id
push_assignment_i  input  1  assigned polarity
push_is_decision_i  input  1  1 = decision (opens new level), 0 = implication
bt_req_i  input  1  backtrack request (sampled in IDLE only)
bt_level_i  input  LEVEL_LEN  target level to keep
bt_busy_o  output  1  high in POP and DONE
bt_done_o  output  1  one-cycle pulse when backtrack completes
unassign_valid_o  output  1  unassign broadcast valid
unassign_ready_i  input  1  clause array accepts unassign
unassign_var_id_o  output  VARIABLE_ENCODING_LEN  variable to clear
unassign_assignment_o  output  1  polarity being cleared
level_o  output  LEVEL_LEN  current decision level
count_o  output  COUNT_LEN  trail occupancy
overflow_o  output  1  sticky: push attempted while full
illegal_id_o  output  1  sticky: push with id 0 or id > FORMULA_MAX_VARIABLE

Behaviour:
- Reset (async, rst_ni low):
  - state=IDLE; count_o=0; level_o=0.
  - push_ready_o=0 while in reset.
  - bt_busy_o, bt_done_o, unassign_valid_o, overflow_o, illegal_id_o = 0.
  - unassign_var_id_o and unassign_assignment_o = 0.
  - Trail RAM contents are don't-care.
  - A reset during POP aborts it; no bt_done_o is issued.
- Entry format: {var_id, assignment, is_decision, level}. Trail is a LIFO; top = index count-1.
- Push ready: push_ready_o = (state==IDLE) && !bt_req_i && (count<TRAIL_DEPTH), combinational.
- Push accept (valid && ready):
  - Decision: level increments, and the entry stores the new level.
  - Implication: entry stores the current level.
  - count increments; the write is visible next cycle.
  - Illegal id: entry is dropped, illegal_id_o set, count unchanged.
- Full: push_valid_i while count==TRAIL_DEPTH in IDLE with no bt_req_i sets overflow_o; the entry is dropped.
- Level saturation: decision at level 2^LEVEL_LEN-1 is dropped and sets overflow_o.
- FSM states: IDLE, POP, DONE.
  - IDLE -> POP: bt_req_i && count>0 && level[top] > bt_level_i. bt_level_i is latched as target.
  - IDLE -> DONE: bt_req_i otherwise (nothing to pop).
  - bt_req_i wins over a same-cycle push; the push is not accepted.
  - POP: unassign_valid_o=1 with the top entry registered onto the outputs. On unassign_ready_i:
    - count decrements.
    - If the popped entry is a decision, level_o decrements.
    - Next top is presented the following cycle.
  - POP -> DONE: the accepted pop leaves count==0 or level[new top] <= target.
  - Valid/data hold stable while unassign_ready_i=0.
  - DONE: bt_done_o=1 for one cycle, then -> IDLE. level_o then equals the target, or 0 if the trail emptied.
- Latency: with unassign_ready_i tied 1, N pops give request at cycle 0, first unassign at cycle 1, last at cycle N, bt_done_o at N+1.
- Zero-pop backtrack: bt_done_o in cycle 1.
- Level-0 implications are never popped.
- bt_req_i outside IDLE is ignored.

Test Plan:
- Reset, then push D(3,1), I(5,0), D(7,1), I(2,1) -> count_o=4, level_o=2; stored levels 1,1,2,2.
- From that state, bt_level_i=1 with ready=1 -> unassigns var 2, then var 7 on consecutive cycles; bt_done_o next cycle; count_o=2, level_o=1.
- Same backtrack with unassign_ready_i toggling 0/1 -> each unassign held stable until accepted; no entry lost or duplicated.
- Push 20 legal entries, then a 21st -> push_ready_o=0, overflow_o=1, count_o stays 20. Push with var_id=0 -> illegal_id_o=1.
- bt_req_i with bt_level_i=3 and level_o=2 -> no unassign_valid_o; bt_done_o at cycle 1. Push and bt_req_i asserted in the same cycle -> push rejected.
- Deassert rst_ni mid-POP -> all outputs 0 immediately; no bt_done_o; count_o=0 after release.
